// File: rtl/weighted_rr_scheduler.sv
// Weighted round-robin arbiter: registered one-hot grant one edge after req is sampled.
// No backpressure: requesters hold req; a grant lasts up to weight beats, idle requesters are skipped.
module weighted_rr_scheduler #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic            grant_vld,
  output logic [IW-1:0]   grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [WW-1:0] credit, credit_nxt;
  logic [N-1:0]  grant_nxt;
  logic          grant_vld_nxt;
  logic [IW-1:0] grant_id_nxt;

  logic [WW-1:0] w_arr [N];
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] cand;
  logic [WW-1:0] sel_credit;
  logic [IW-1:0] sel_ptr;
  logic          load;
  logic          release_cur;

  for (genvar g = 0; g < N; g++) begin : g_w
    assign w_arr[g] = weight[g*WW +: WW];
  end

  // Scan ptr, ptr+1, ... mod N; the first requester found wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign sel_credit = (w_arr[sel_idx] == '0) ? WW'(1) : w_arr[sel_idx];
  assign sel_ptr    = (sel_idx == IW'(N-1)) ? '0 : sel_idx + IW'(1);

  // A grant ends when its owner drops req, or on the beat that spends the last credit.
  assign release_cur = !req[grant_id] || (credit == WW'(1));

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    credit_nxt    = credit;
    grant_nxt     = grant;
    grant_vld_nxt = grant_vld;
    grant_id_nxt  = grant_id;
    load          = 1'b0;

    case (state)
      IDLE: begin
        if (sel_found) load = 1'b1;
      end
      GRANT: begin
        if (release_cur) begin
          if (sel_found) begin
            load = 1'b1;
          end else begin
            state_nxt     = IDLE;
            grant_nxt     = '0;
            grant_vld_nxt = 1'b0;
            grant_id_nxt  = '0;
            credit_nxt    = '0;
          end
        end else begin
          credit_nxt = credit - WW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      state_nxt     = GRANT;
      grant_nxt     = N'(1) << sel_idx;
      grant_vld_nxt = 1'b1;
      grant_id_nxt  = sel_idx;
      credit_nxt    = sel_credit;
      ptr_nxt       = sel_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      credit    <= '0;
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      credit    <= credit_nxt;
      grant     <= grant_nxt;
      grant_vld <= grant_vld_nxt;
      grant_id  <= grant_id_nxt;
    end
  end

endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// Directed vector table plus hand-written reset sequence and a random phase under per-cycle checkers.
module tb_weighted_rr_scheduler;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  localparam logic [15:0] W1 = 16'h1111;
  localparam logic [15:0] W3 = 16'h1213;
  localparam logic [15:0] W4 = 16'h4444;
  localparam logic [15:0] W5 = 16'h0444;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic            grant_vld;
  logic [IW-1:0]   grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weighted_rr_scheduler #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .weight    (weight),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  typedef struct {
    int          grp;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int grp, input logic r, input logic [3:0] rq,
                     input logic [15:0] w, input logic [3:0] e);
    vec_t v;
    v.grp = grp; v.rst = r; v.req = rq; v.weight = w; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [N-1:0] exp);
    n_tests++;
    if (grant !== exp || grant_vld !== (|exp) || grant_id !== idx_of(exp)) begin
      n_fail++;
      $display("FAIL %s: got grant=%b vld=%b id=%0d, want grant=%b vld=%b id=%0d",
               name, grant, grant_vld, grant_id, exp, |exp, idx_of(exp));
    end
  endtask

  // Per-cycle invariants, including the starvation bound
  logic [N-1:0] req_q;
  logic         chk_en = 1'b0;
  int           wait_cnt [N];

  always @(posedge clk) req_q <= req;

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ($countones(grant) > 1 || grant_vld !== (|grant) || grant_id !== idx_of(grant)) begin
        n_fail++;
        $display("FAIL onehot_id: grant=%b vld=%b id=%0d", grant, grant_vld, grant_id);
      end
      n_tests++;
      if ((grant & ~req_q) != '0) begin
        n_fail++;
        $display("FAIL req_only: grant=%b sampled req=%b", grant, req_q);
      end
      for (int i = 0; i < N; i++) begin
        int bound;
        bound = N;
        for (int j = 0; j < N; j++) begin
          if (j != i) bound += (weight[j*WW +: WW] == 0) ? 1 : int'(weight[j*WW +: WW]);
        end
        if (rst || grant[i] || !req_q[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        n_tests++;
        if (wait_cnt[i] > bound) begin
          n_fail++;
          $display("FAIL starve_%0d: waited %0d cycles, bound %0d", i, wait_cnt[i], bound);
          wait_cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    req    = '0;
    weight = W1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    // 1: reset then idle
    repeat (2) add(1, 1'b1, 4'h0, W1, 4'h0);
    repeat (8) add(1, 1'b0, 4'h0, W1, 4'h0);
    // 2: unit weights, all requesting
    add(2, 1'b0, 4'hF, W1, 4'b0001);
    add(2, 1'b0, 4'hF, W1, 4'b0010);
    add(2, 1'b0, 4'hF, W1, 4'b0100);
    add(2, 1'b0, 4'hF, W1, 4'b1000);
    add(2, 1'b0, 4'hF, W1, 4'b0001);
    add(2, 1'b1, 4'h0, W3, 4'h0);
    // 3: weights {3,1,2,1}
    repeat (3) add(3, 1'b0, 4'hF, W3, 4'b0001);
    add(3, 1'b0, 4'hF, W3, 4'b0010);
    repeat (2) add(3, 1'b0, 4'hF, W3, 4'b0100);
    add(3, 1'b0, 4'hF, W3, 4'b1000);
    repeat (3) add(3, 1'b0, 4'hF, W3, 4'b0001);
    add(3, 1'b0, 4'hF, W3, 4'b0010);
    add(3, 1'b1, 4'h0, W4, 4'h0);
    // 4: single requester, back-to-back regrant, then drop
    repeat (6) add(4, 1'b0, 4'b0100, W4, 4'b0100);
    add(4, 1'b0, 4'b0000, W4, 4'b0000);
    add(4, 1'b0, 4'b0100, W4, 4'b0100);
    add(4, 1'b1, 4'h0, W4, 4'h0);
    // 5: owner drops after 2 beats, then zero weight regrants
    repeat (3) add(5, 1'b0, 4'b0101, W4, 4'b0001);
    repeat (2) add(5, 1'b0, 4'b0100, W4, 4'b0100);
    repeat (4) add(5, 1'b0, 4'b1000, W5, 4'b1000);
    add(5, 1'b1, 4'h0, W4, 4'h0);

    @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      rst    = vecs[k].rst;
      req    = vecs[k].req;
      weight = vecs[k].weight;
      @(negedge clk);
      check($sformatf("t%0d_vec%0d", vecs[k].grp, k), vecs[k].exp);
    end

    // 6: asynchronous reset mid-grant, scan restarts at index 0
    rst = 1'b0; req = 4'b0100; weight = W4;
    @(negedge clk);
    check("t6_pre", 4'b0100);
    rst = 1'b1;
    #1;
    check("t6_async_clear", 4'b0000);
    @(negedge clk);
    check("t6_in_reset", 4'b0000);
    rst = 1'b0; req = 4'hF;
    @(negedge clk);
    check("t6_first_after_reset", 4'b0001);

    // Random sticky requests; weights change only while idle
    for (int s = 0; s < 8; s++) begin
      req = '0;
      repeat (2) @(negedge clk);
      weight = 16'($urandom);
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        @(negedge clk);
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
